// File: rtl/pwm_deadtime_v1_0.sv
// pwm_deadtime_v1_0: splits a single pwm into complementary gate drives with a programmable dead gap.
// Define DEADTIME_FAULT_EN to add the fault trip input, clear input and latched fault state.
module pwm_deadtime_v1_0 #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    input  logic [width-1:0] deadtime,
`ifdef DEADTIME_FAULT_EN
    input  logic             fault,
    input  logic             fault_clr,
    output logic             fault_latched,
`endif
    output logic             pwm_h,
    output logic             pwm_l,
    output logic             dt_active
);

    // state   | meaning
    // S_LOW   | low-side gate on
    // S_HIGH  | high-side gate on
    // S_DT    | both gates off, counting toward target level
    // S_FAULT | both gates off until fault cleared (fault build only)
    typedef enum logic [1:0] {
        S_LOW   = 2'd0,
        S_HIGH  = 2'd1,
        S_DT    = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic             target, target_nxt;
    logic [width-1:0] cnt, cnt_nxt;
    logic [width-1:0] dt_reg, dt_nxt;
    logic             pwm_q;
    logic [width:0]   cnt_inc;

    // one extra bit so cnt+1 cannot wrap against a full-scale dead time
    assign cnt_inc = {1'b0, cnt} + {{width{1'b0}}, 1'b1};

    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        cnt_nxt    = cnt;
        dt_nxt     = dt_reg;
        case (state)
            S_LOW: begin
                if (pwm_q) begin
                    state_nxt  = S_DT;
                    target_nxt = 1'b1;
                    cnt_nxt    = '0;
                    dt_nxt     = deadtime;
                end
            end
            S_HIGH: begin
                if (!pwm_q) begin
                    state_nxt  = S_DT;
                    target_nxt = 1'b0;
                    cnt_nxt    = '0;
                    dt_nxt     = deadtime;
                end
            end
            S_DT: begin
                if (pwm_q != target) begin
                    target_nxt = pwm_q;
                    cnt_nxt    = '0;
                end else if (cnt_inc >= {1'b0, dt_reg}) begin
                    state_nxt = target ? S_HIGH : S_LOW;
                end else begin
                    cnt_nxt = cnt_inc[width-1:0];
                end
            end
`ifdef DEADTIME_FAULT_EN
            S_FAULT: begin
                if (fault_clr && !fault) begin
                    state_nxt  = S_DT;
                    target_nxt = pwm_q;
                    cnt_nxt    = '0;
                    dt_nxt     = deadtime;
                end
            end
`endif
            default: begin
                state_nxt  = S_DT;
                target_nxt = 1'b0;
                cnt_nxt    = '0;
            end
        endcase
`ifdef DEADTIME_FAULT_EN
        // a trip overrides whatever the normal sequencing decided this cycle
        if (fault) begin
            state_nxt = S_FAULT;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_DT;
            target    <= 1'b0;
            cnt       <= '0;
            dt_reg    <= deadtime;
            pwm_q     <= 1'b0;
            pwm_h     <= 1'b0;
            pwm_l     <= 1'b0;
            dt_active <= 1'b1;
`ifdef DEADTIME_FAULT_EN
            fault_latched <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            target    <= target_nxt;
            cnt       <= cnt_nxt;
            dt_reg    <= dt_nxt;
            pwm_q     <= pwm_in;
            pwm_h     <= (state_nxt == S_HIGH);
            pwm_l     <= (state_nxt == S_LOW);
            dt_active <= (state_nxt == S_DT);
`ifdef DEADTIME_FAULT_EN
            fault_latched <= (state_nxt == S_FAULT);
`endif
        end
    end

endmodule
